// File: rtl/memn2n_pkg.sv
// Shared types and default timing constants for the MemN2N story sequencer.
//   seq_state_e : sequencer FSM states
//   seq_phase_e : which kind of word is being processed (sentence, question, answer)
package memn2n_pkg;

  localparam int unsigned MEMN2N_INIT_CYCLES = 60;
  localparam int unsigned MEMN2N_PROC_CYCLES = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_INIT_WAIT,
    ST_POP,
    ST_LOAD,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_SENT,
    PH_QUES,
    PH_ANS
  } seq_phase_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used for the init wait and the per-word enable window.
//   clk, rst : clock, async active-high reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : cycles to count
//   value    : remaining count, decrements once per cycle until 0
//   zero     : registered flag, high while value == 0
module cycle_timer #(
  parameter int unsigned BW_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BW_CNT-1:0] load_val,
  output logic [BW_CNT-1:0] value,
  output logic              zero
);

  // zero tracks value one step ahead so it stays registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      value <= load_val;
      zero  <= (load_val == '0);
    end else if (!zero) begin
      value <= value - BW_CNT'(1);
      zero  <= (value == BW_CNT'(1));
    end
  end

endmodule

// File: rtl/memn2n_seq_ctrl.sv
// Story sequencer between the input FIFO and the MemN2N core.
//   start/cfg_nsent/cfg_train : story request, sampled in IDLE only
//   fifo_dout/fifo_empty/fifo_rd_en : FIFO read side, data one cycle after pop
//   data_in  : word held stable for the core during its en window
//   en/en_init/we_query/f_w_up : core control strobes
//   busy/done : status; done pulses once per completed story
// All outputs are registered.
module memn2n_seq_ctrl
  import memn2n_pkg::*;
#(
  parameter int unsigned BW_DATA_IN  = 32,
  parameter int unsigned INIT_CYCLES = MEMN2N_INIT_CYCLES,
  parameter int unsigned PROC_CYCLES = MEMN2N_PROC_CYCLES,
  parameter int unsigned BW_NSENT    = 6,
  parameter int unsigned BW_CNT      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BW_NSENT-1:0]   cfg_nsent,
  input  logic                  cfg_train,
  input  logic [BW_DATA_IN-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [BW_DATA_IN-1:0] data_in,
  output logic                  en,
  output logic                  en_init,
  output logic                  we_query,
  output logic                  f_w_up,
  output logic                  busy,
  output logic                  done
);

  seq_state_e            state_q, state_d;
  seq_phase_e            phase_q, phase_d;
  logic [BW_NSENT-1:0]   sent_q, sent_d;
  logic [BW_NSENT-1:0]   nsent_q, nsent_d;
  logic                  train_q, train_d;
  logic [BW_DATA_IN-1:0] data_d;
  logic                  rd_en_d, en_d, en_init_d, we_query_d, f_w_up_d, busy_d, done_d;

  logic                  timer_load;
  logic [BW_CNT-1:0]     timer_load_val;
  logic [BW_CNT-1:0]     timer_value;
  logic                  timer_zero;
  logic                  timer_last;

  // Timer is loaded on the INIT and LOAD edges so the wait starts in the next state
  assign timer_load     = (state_q == ST_INIT) || (state_q == ST_LOAD);
  assign timer_load_val = (state_q == ST_INIT) ? BW_CNT'(INIT_CYCLES) :
                          (phase_q == PH_ANS)  ? BW_CNT'(1)           :
                                                 BW_CNT'(PROC_CYCLES);
  // Last cycle of a wait; the zero term also lets a zero-length wait fall through
  assign timer_last     = timer_zero || (timer_value == BW_CNT'(1));

  cycle_timer #(
    .BW_CNT(BW_CNT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_load_val),
    .value   (timer_value),
    .zero    (timer_zero)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sent_d  = sent_q;
    nsent_d = nsent_q;
    train_d = train_q;
    data_d  = data_in;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          nsent_d = cfg_nsent;
          train_d = cfg_train;
          sent_d  = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT:      state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (timer_last) begin
          state_d = ST_POP;
          phase_d = (nsent_q == '0) ? PH_QUES : PH_SENT;
        end
      end
      // The pop strobe is already high in this cycle when the FIFO was non-empty
      ST_POP:  if (fifo_rd_en) state_d = ST_LOAD;
      ST_LOAD: begin
        data_d  = fifo_dout;
        state_d = ST_RUN;
      end
      ST_RUN:  if (timer_last) state_d = ST_GAP;
      ST_GAP: begin
        state_d = ST_POP;
        case (phase_q)
          PH_SENT: begin
            sent_d = sent_q + BW_NSENT'(1);
            if (sent_d == nsent_q) phase_d = PH_QUES;
          end
          PH_QUES: phase_d = PH_ANS;
          default: state_d = ST_DONE;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    rd_en_d    = (state_d == ST_POP) && !fifo_empty;
    en_d       = (state_d == ST_RUN);
    en_init_d  = (state_d == ST_INIT);
    we_query_d = (state_d == ST_RUN) && (phase_d == PH_QUES);
    f_w_up_d   = (state_d == ST_RUN) && (phase_d == PH_ANS) && train_d;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_SENT;
      sent_q     <= '0;
      nsent_q    <= '0;
      train_q    <= 1'b0;
      data_in    <= '0;
      fifo_rd_en <= 1'b0;
      en         <= 1'b0;
      en_init    <= 1'b0;
      we_query   <= 1'b0;
      f_w_up     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sent_q     <= sent_d;
      nsent_q    <= nsent_d;
      train_q    <= train_d;
      data_in    <= data_d;
      fifo_rd_en <= rd_en_d;
      en         <= en_d;
      en_init    <= en_init_d;
      we_query   <= we_query_d;
      f_w_up     <= f_w_up_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_memn2n_seq_ctrl.sv
// Directed bench for memn2n_seq_ctrl with a behavioural FIFO and an en-window monitor.
module tb_memn2n_seq_ctrl;

  localparam int unsigned BW    = 32;
  localparam int unsigned INITC = 60;
  localparam int unsigned PROC  = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    cfg_nsent;
  logic          cfg_train;
  logic [BW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [BW-1:0] data_in;
  logic          en, en_init, we_query, f_w_up, busy, done;

  int n_chk = 0;
  int n_pass = 0;

  memn2n_seq_ctrl #(
    .BW_DATA_IN(BW), .INIT_CYCLES(INITC), .PROC_CYCLES(PROC), .BW_NSENT(6), .BW_CNT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_nsent(cfg_nsent), .cfg_train(cfg_train),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .data_in(data_in), .en(en), .en_init(en_init), .we_query(we_query),
    .f_w_up(f_w_up), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears one cycle after the pop strobe
  logic [BW-1:0] fifo_q [$];
  int fifo_cnt = 0;
  int pops_empty = 0;
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_cnt > 0) begin
        fifo_dout = fifo_q.pop_front();
        fifo_cnt  = fifo_cnt - 1;
      end else begin
        pops_empty = pops_empty + 1;
      end
    end
  end

  // Monitor, sampled on the falling edge
  int cyc = 0;
  int cur_len, n_win, rd_cnt, done_cnt, init_cnt, busy_cyc;
  int stable_err, lat_err, stray_we, stray_fwu;
  int start_cyc, init_cyc, first_rd_cyc, last_rd_cyc;
  int cur_we, cur_fwu;
  logic [BW-1:0] cur_data, prev_data;
  int win_len [8];
  int win_we [8];
  int win_fwu [8];
  logic [BW-1:0] win_data [8];
  logic [BW-1:0] story_w [4];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (start && !busy) start_cyc = cyc;
    if (en_init) begin init_cnt++; init_cyc = cyc; end
    if (fifo_rd_en) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (data_in !== prev_data) begin
      if (cyc - last_rd_cyc != 2) lat_err++;
      prev_data = data_in;
    end
    if (en) begin
      if (cur_len == 0) begin cur_data = data_in; cur_we = 0; cur_fwu = 0; end
      else if (data_in !== cur_data) stable_err++;
      cur_len++;
      cur_we  += int'(we_query);
      cur_fwu += int'(f_w_up);
    end else begin
      if (we_query) stray_we++;
      if (f_w_up) stray_fwu++;
      if (cur_len > 0) begin
        if (n_win < 8) begin
          win_len[n_win] = cur_len; win_data[n_win] = cur_data;
          win_we[n_win] = cur_we; win_fwu[n_win] = cur_fwu;
        end
        n_win++;
        cur_len = 0;
      end
    end
  end

  task automatic clear_mon();
    cur_len = 0; n_win = 0; rd_cnt = 0; done_cnt = 0; init_cnt = 0; busy_cyc = 0;
    stable_err = 0; lat_err = 0; stray_we = 0; stray_fwu = 0; pops_empty = 0;
    start_cyc = 0; init_cyc = 0; first_rd_cyc = 0; last_rd_cyc = -100;
    prev_data = data_in;
  endtask

  task automatic push_word(input logic [BW-1:0] w);
    fifo_q.push_back(w);
    fifo_cnt = fifo_cnt + 1;
  endtask

  task automatic pulse_start(input int ns, input bit tr);
    @(posedge clk); #1;
    start = 1'b1; cfg_nsent = 6'(ns); cfg_train = tr;
    @(posedge clk); #1;
    start = 1'b0; cfg_nsent = 6'd0; cfg_train = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    n_chk++; if (done_cnt == 0) $display("FAIL done_timeout: done never seen, want 1 pulse"); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_nsent = '0; cfg_train = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({fifo_rd_en, en, en_init, we_query, f_w_up, busy, done} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {fifo_rd_en, en, en_init, we_query, f_w_up, busy, done});
    else n_pass++;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (data_in !== '0) $display("FAIL reset_data: got %h want 0", data_in); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_story(input bit tr);
    clear_mon();
    for (int i = 0; i < 4; i++) push_word(story_w[i]);
    pulse_start(2, tr);
    wait_done();
    n_chk++; if (rd_cnt !== 4) $display("FAIL story_pops: got %0d want 4", rd_cnt); else n_pass++;
    n_chk++; if (n_win !== 4) $display("FAIL story_windows: got %0d want 4", n_win); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (win_len[i] !== ((i < 3) ? int'(PROC) : 1))
        $display("FAIL story_en_len[%0d]: got %0d want %0d", i, win_len[i], (i < 3) ? int'(PROC) : 1);
      else n_pass++;
      n_chk++; if (win_data[i] !== story_w[i])
        $display("FAIL story_data[%0d]: got %h want %h", i, win_data[i], story_w[i]);
      else n_pass++;
      n_chk++; if (win_we[i] !== ((i == 2) ? int'(PROC) : 0))
        $display("FAIL story_we_query[%0d]: got %0d want %0d", i, win_we[i], (i == 2) ? int'(PROC) : 0);
      else n_pass++;
      n_chk++; if (win_fwu[i] !== ((tr && i == 3) ? 1 : 0))
        $display("FAIL story_f_w_up[%0d]: got %0d want %0d", i, win_fwu[i], (tr && i == 3) ? 1 : 0);
      else n_pass++;
    end
    n_chk++; if (stray_we + stray_fwu !== 0) $display("FAIL story_stray: got %0d want 0", stray_we + stray_fwu); else n_pass++;
    n_chk++; if (done_cnt !== 1) $display("FAIL story_done: got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (stable_err !== 0) $display("FAIL story_stable: got %0d want 0", stable_err); else n_pass++;
    n_chk++; if (lat_err !== 0) $display("FAIL story_rd_to_data: got %0d want 0", lat_err); else n_pass++;
    n_chk++; if (init_cyc - start_cyc !== 1) $display("FAIL story_start_to_init: got %0d want 1", init_cyc - start_cyc); else n_pass++;
    n_chk++; if (first_rd_cyc - init_cyc !== int'(INITC) + 1)
      $display("FAIL story_init_to_pop: got %0d want %0d", first_rd_cyc - init_cyc, INITC + 1);
    else n_pass++;
    n_chk++; if (busy_cyc !== 195) $display("FAIL story_time: got %0d want 195", busy_cyc); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL story_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stall();
    int bad = 0;
    clear_mon();
    push_word(story_w[0]);
    pulse_start(2, 1'b0);
    for (int i = 0; i < 500 && n_win < 1; i++) @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (fifo_rd_en || en || !busy) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad); else n_pass++;
    n_chk++; if (rd_cnt !== 1) $display("FAIL stall_pops: got %0d want 1", rd_cnt); else n_pass++;
    for (int i = 1; i < 4; i++) push_word(story_w[i]);
    wait_done();
    n_chk++; if (rd_cnt !== 4) $display("FAIL stall_total_pops: got %0d want 4", rd_cnt); else n_pass++;
    n_chk++; if (pops_empty !== 0) $display("FAIL stall_empty_pop: got %0d want 0", pops_empty); else n_pass++;
    n_chk++; if (n_win !== 4) $display("FAIL stall_windows: got %0d want 4", n_win); else n_pass++;
    n_chk++; if (win_len[1] !== int'(PROC)) $display("FAIL stall_en_len: got %0d want %0d", win_len[1], PROC); else n_pass++;
    n_chk++; if (win_data[1] !== story_w[1]) $display("FAIL stall_data: got %h want %h", win_data[1], story_w[1]); else n_pass++;
  endtask

  task automatic test_nsent0();
    clear_mon();
    push_word(32'h0000_00aa);
    push_word(32'h0000_00bb);
    pulse_start(0, 1'b1);
    wait_done();
    n_chk++; if (rd_cnt !== 2) $display("FAIL nsent0_pops: got %0d want 2", rd_cnt); else n_pass++;
    n_chk++; if (n_win !== 2) $display("FAIL nsent0_windows: got %0d want 2", n_win); else n_pass++;
    n_chk++; if (win_we[0] !== int'(PROC)) $display("FAIL nsent0_we_query: got %0d want %0d", win_we[0], PROC); else n_pass++;
    n_chk++; if (win_len[1] !== 1) $display("FAIL nsent0_ans_len: got %0d want 1", win_len[1]); else n_pass++;
    n_chk++; if (win_fwu[1] !== 1) $display("FAIL nsent0_f_w_up: got %0d want 1", win_fwu[1]); else n_pass++;
    n_chk++; if (win_data[0] !== 32'h0000_00aa) $display("FAIL nsent0_data: got %h want 000000aa", win_data[0]); else n_pass++;
    n_chk++; if (busy_cyc !== 109) $display("FAIL nsent0_time: got %0d want 109", busy_cyc); else n_pass++;
  endtask

  task automatic test_rst_mid();
    clear_mon();
    for (int i = 0; i < 4; i++) push_word(story_w[i]);
    pulse_start(2, 1'b1);
    for (int i = 0; i < 500 && cur_len < 10; i++) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({fifo_rd_en, en, en_init, we_query, f_w_up, busy, done} !== 7'b0 || data_in !== '0)
      $display("FAIL rst_mid_outputs: got %b/%h want 0000000/0",
               {fifo_rd_en, en, en_init, we_query, f_w_up, busy, done}, data_in);
    else n_pass++;
    @(posedge clk); #2 rst = 1'b0;
    fifo_q.delete();
    fifo_cnt = 0;
    @(posedge clk); #1;
    clear_mon();
    for (int i = 0; i < 4; i++) push_word(story_w[i]);
    pulse_start(2, 1'b0);
    wait_done();
    n_chk++; if (init_cnt !== 1) $display("FAIL rst_restart_init: got %0d want 1", init_cnt); else n_pass++;
    n_chk++; if (n_win !== 4) $display("FAIL rst_restart_windows: got %0d want 4", n_win); else n_pass++;
    n_chk++; if (win_data[0] !== story_w[0]) $display("FAIL rst_restart_data: got %h want %h", win_data[0], story_w[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 4; i++) push_word(story_w[i]);
    pulse_start(2, 1'b0);
    repeat (30) @(posedge clk);
    pulse_start(5, 1'b1);
    repeat (70) @(posedge clk);
    pulse_start(0, 1'b1);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    n_chk++; if (done_cnt !== 1) $display("FAIL b2b_done: got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (init_cnt !== 1) $display("FAIL b2b_init: got %0d want 1", init_cnt); else n_pass++;
    n_chk++; if (rd_cnt !== 4) $display("FAIL b2b_pops: got %0d want 4", rd_cnt); else n_pass++;
    n_chk++; if (win_fwu[3] !== 0) $display("FAIL b2b_f_w_up: got %0d want 0", win_fwu[3]); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    story_w[0] = 32'h0080_00fc;
    story_w[1] = 32'h0000_0011;
    story_w[2] = 32'h0000_0022;
    story_w[3] = 32'h0000_0033;
    fifo_dout = '0;
    test_reset();
    test_story(1'b0);
    test_story(1'b1);
    test_stall();
    test_nsent0();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
